// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner with frame-based debounce.
// One column is strobed per scan tick; a key is accepted or released after STABLE_FRAMES identical frames.
module keypad_scanner #(
    parameter int SCAN_DIV      = 50000,
    parameter int STABLE_FRAMES = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic       key_vaild,
    output logic [3:0] key_code
);
    localparam int               DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0]       STABLE_N = 4'(STABLE_FRAMES);

    typedef enum logic [1:0] {IDLE, CAND, PRESSED, REL} state_t;

    logic [3:0]       row_s1_q, row_s1_d;
    logic [3:0]       row_s2_q, row_s2_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       col_idx_q, col_idx_d;
    logic [3:0]       col_out_q, col_out_d;
    logic [1:0]       hit_cnt_q, hit_cnt_d;
    logic [3:0]       first_code_q, first_code_d;
    logic             frame_vld_q, frame_vld_d;
    logic             frame_single_q, frame_single_d;
    logic [3:0]       frame_code_q, frame_code_d;
    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [3:0]       cand_q, cand_d;
    logic             key_vaild_q, key_vaild_d;
    logic [3:0]       key_code_q, key_code_d;

    logic       tick;
    logic [3:0] row_hits;
    logic [2:0] tick_hits;
    logic [2:0] hit_sum;
    logic [1:0] first_row;
    logic [3:0] code_now;
    logic [3:0] cnt_inc;
    logic       same_key;

    // Scan divider, column strobe and per-frame hit accumulation
    always_comb begin
        row_s1_d       = row_in;
        row_s2_d       = row_s1_q;
        tick           = (div_q == DIV_LAST);
        div_d          = tick ? '0 : div_q + DIV_W'(1);
        col_idx_d      = col_idx_q;
        col_out_d      = col_out_q;
        hit_cnt_d      = hit_cnt_q;
        first_code_d   = first_code_q;
        frame_vld_d    = 1'b0;
        frame_single_d = frame_single_q;
        frame_code_d   = frame_code_q;

        row_hits  = ~row_s2_q;
        tick_hits = {2'b00, row_hits[0]} + {2'b00, row_hits[1]}
                  + {2'b00, row_hits[2]} + {2'b00, row_hits[3]};
        hit_sum   = {1'b0, hit_cnt_q} + tick_hits;

        if (row_hits[0])      first_row = 2'd0;
        else if (row_hits[1]) first_row = 2'd1;
        else if (row_hits[2]) first_row = 2'd2;
        else                  first_row = 2'd3;

        // Only the earliest hit in scan order is kept as the frame's candidate code
        if (hit_cnt_q == 2'd0 && row_hits != 4'b0000) code_now = {first_row, col_idx_q};
        else                                          code_now = first_code_q;

        if (tick) begin
            col_idx_d = col_idx_q + 2'd1;
            col_out_d = ~(4'b0001 << col_idx_d);
            if (col_idx_q == 2'd3) begin
                frame_vld_d    = 1'b1;
                frame_single_d = (hit_sum == 3'd1);
                frame_code_d   = code_now;
                hit_cnt_d      = 2'd0;
                first_code_d   = 4'd0;
            end else begin
                hit_cnt_d    = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
                first_code_d = code_now;
            end
        end
    end

    // Debounce FSM, stepped once per completed frame
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cand_d      = cand_q;
        key_vaild_d = key_vaild_q;
        key_code_d  = key_code_q;
        cnt_inc     = cnt_q + 4'd1;
        same_key    = frame_single_q && (frame_code_q == key_code_q);

        if (frame_vld_q) begin
            case (state_q)
                IDLE: begin
                    if (frame_single_q) begin
                        cand_d = frame_code_q;
                        cnt_d  = 4'd1;
                        if (STABLE_FRAMES == 1) begin
                            state_d     = PRESSED;
                            key_code_d  = frame_code_q;
                            key_vaild_d = 1'b1;
                        end else begin
                            state_d = CAND;
                        end
                    end
                end
                CAND: begin
                    if (!frame_single_q) begin
                        state_d = IDLE;
                    end else if (frame_code_q == cand_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= STABLE_N) begin
                            state_d     = PRESSED;
                            key_code_d  = cand_q;
                            key_vaild_d = 1'b1;
                        end
                    end else begin
                        cand_d = frame_code_q;
                        cnt_d  = 4'd1;
                    end
                end
                PRESSED: begin
                    if (!same_key) begin
                        if (STABLE_FRAMES == 1) begin
                            state_d     = IDLE;
                            key_vaild_d = 1'b0;
                        end else begin
                            state_d = REL;
                            cnt_d   = 4'd1;
                        end
                    end
                end
                REL: begin
                    if (same_key) begin
                        state_d = PRESSED;
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= STABLE_N) begin
                            state_d     = IDLE;
                            key_vaild_d = 1'b0;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_s1_q       <= 4'b1111;
            row_s2_q       <= 4'b1111;
            div_q          <= '0;
            col_idx_q      <= 2'd0;
            col_out_q      <= 4'b1110;
            hit_cnt_q      <= 2'd0;
            first_code_q   <= 4'd0;
            frame_vld_q    <= 1'b0;
            frame_single_q <= 1'b0;
            frame_code_q   <= 4'd0;
            state_q        <= IDLE;
            cnt_q          <= 4'd0;
            cand_q         <= 4'd0;
            key_vaild_q    <= 1'b0;
            key_code_q     <= 4'd0;
        end else begin
            row_s1_q       <= row_s1_d;
            row_s2_q       <= row_s2_d;
            div_q          <= div_d;
            col_idx_q      <= col_idx_d;
            col_out_q      <= col_out_d;
            hit_cnt_q      <= hit_cnt_d;
            first_code_q   <= first_code_d;
            frame_vld_q    <= frame_vld_d;
            frame_single_q <= frame_single_d;
            frame_code_q   <= frame_code_d;
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            cand_q         <= cand_d;
            key_vaild_q    <= key_vaild_d;
            key_code_q     <= key_code_d;
        end
    end

    assign col_out   = col_out_q;
    assign key_vaild = key_vaild_q;
    assign key_code  = key_code_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: per-frame vector table plus reset and column-step sequences.
// Key bit r*4+c of keys pulls row r low while column c is driven; its code equals that index.
module tb_keypad_scanner;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic        key_vaild;
    logic [3:0]  key_code;
    logic [15:0] keys = 16'h0000;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [15:0] keys;
        logic        vld;
        logic [3:0]  code;
    } vec_t;

    vec_t vq[$];

    always #5 clk = ~clk;

    keypad_scanner #(.SCAN_DIV(4), .STABLE_FRAMES(2)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .row_in   (row_in),
        .col_out  (col_out),
        .key_vaild(key_vaild),
        .key_code (key_code)
    );

    // Passive keypad matrix
    always_comb begin
        row_in = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
    end

    task automatic check(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic [15:0] k, input logic v, input logic [3:0] c);
        vec_t e;
        e.keys = k;
        e.vld  = v;
        e.code = c;
        vq.push_back(e);
    endtask

    // Advance one frame from 1 clk after a frame edge to 1 clk after the next
    task automatic run_frame();
        repeat (16) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] one;
        logic [3:0] exp_col;
        logic       prev_vld;
        one = 4'b0001;

        // Vectors start from IDLE, key_code 0; one row per frame
        add(16'h0200, 1'b0, 4'h0);
        add(16'h0200, 1'b1, 4'h9);
        add(16'h0000, 1'b1, 4'h9);
        add(16'h0000, 1'b0, 4'h9);
        add(16'h0200, 1'b0, 4'h9);
        add(16'h0000, 1'b0, 4'h9);
        add(16'h0200, 1'b0, 4'h9);
        add(16'h0200, 1'b1, 4'h9);
        add(16'h0000, 1'b1, 4'h9);
        add(16'h0200, 1'b1, 4'h9);
        add(16'h0200, 1'b1, 4'h9);
        add(16'h0000, 1'b1, 4'h9);
        add(16'h0000, 1'b0, 4'h9);
        add(16'h8001, 1'b0, 4'h9);
        add(16'h8001, 1'b0, 4'h9);
        add(16'h8001, 1'b0, 4'h9);
        add(16'h0020, 1'b0, 4'h9);
        add(16'h0020, 1'b1, 4'h5);
        add(16'h0420, 1'b1, 4'h5);
        add(16'h0420, 1'b0, 4'h5);
        add(16'h0040, 1'b0, 4'h5);
        add(16'h0040, 1'b1, 4'h6);
        add(16'h0008, 1'b1, 4'h6);
        add(16'h0008, 1'b0, 4'h6);
        add(16'h0008, 1'b0, 4'h6);
        add(16'h0008, 1'b1, 4'h3);
        add(16'h0000, 1'b1, 4'h3);
        add(16'h0000, 1'b0, 4'h3);
        add(16'h1000, 1'b0, 4'h3);
        add(16'h0080, 1'b0, 4'h3);
        add(16'h0080, 1'b1, 4'h7);
        add(16'h0000, 1'b1, 4'h7);
        add(16'h0000, 1'b0, 4'h7);
        add(16'h0110, 1'b0, 4'h7);
        add(16'h0110, 1'b0, 4'h7);
        add(16'h0110, 1'b0, 4'h7);
        add(16'h0000, 1'b0, 4'h7);

        // Reset values while held
        @(posedge clk);
        #2;
        check("rst_col", 0, col_out, 4'b1110);
        check("rst_vld", 0, {3'b000, key_vaild}, 4'h0);
        check("rst_code", 0, key_code, 4'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Column strobe steps every SCAN_DIV clocks
        for (int n = 1; n <= 16; n++) begin
            @(posedge clk);
            #1;
            exp_col = ~(one << ((n / 4) % 4));
            check("col_step", n, col_out, exp_col);
        end
        @(posedge clk);
        #1;
        check("idle_vld", 0, {3'b000, key_vaild}, 4'h0);

        prev_vld = 1'b0;
        for (int i = 0; i < vq.size(); i++) begin
            keys = vq[i].keys;
            repeat (15) @(posedge clk);
            #1;
            check("vld_hold", i, {3'b000, key_vaild}, {3'b000, prev_vld});
            @(posedge clk);
            #1;
            check("vld", i, {3'b000, key_vaild}, {3'b000, vq[i].vld});
            check("code", i, key_code, vq[i].code);
            check("col", i, col_out, 4'b1110);
            prev_vld = vq[i].vld;
        end

        // Press key 5, then an unaligned asynchronous reset while it is held
        keys = 16'h0020;
        run_frame();
        run_frame();
        check("pre_rst_vld", 0, {3'b000, key_vaild}, 4'h1);
        check("pre_rst_code", 0, key_code, 4'h5);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("arst_vld", 0, {3'b000, key_vaild}, 4'h0);
        check("arst_col", 0, col_out, 4'b1110);
        check("arst_code", 0, key_code, 4'h0);
        repeat (2) @(posedge clk);
        #4;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        run_frame();
        check("post_rst_vld", 1, {3'b000, key_vaild}, 4'h0);
        run_frame();
        check("post_rst_vld", 2, {3'b000, key_vaild}, 4'h1);
        check("post_rst_code", 2, key_code, 4'h5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
